seq_multiplier: RTL and testbench

SEQ_MULTIPLIER -- requirements
Module: seq_multiplier

---
 rtl/seq_multiplier.sv | 91 +++++++++
 tb/tb_seq_multiplier.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_multiplier.sv
// Sequential shift-add unsigned multiplier with valid/ready handshakes.
// Optional early termination when SEQ_MULTIPLIER_EARLY_TERM_EN is defined.
module seq_multiplier #(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] p,
    output logic               busy
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state;
    state_t             state_nxt;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] mcand;
    logic [2*WIDTH-1:0] result;
    logic [2*WIDTH-1:0] acc_step;
    logic [WIDTH-1:0]   mplr;
    logic [WIDTH-1:0]   mplr_shift;
    logic [CW-1:0]      cnt;
    logic               last_step;

    always_comb begin
        acc_step   = mplr[0] ? acc + mcand : acc;
        mplr_shift = mplr >> 1;
`ifdef SEQ_MULTIPLIER_EARLY_TERM_EN
        // Stop once no multiplier bits remain; b == 0 still takes one step.
        last_step  = (cnt == CW'(WIDTH - 1)) || (mplr_shift == '0);
`else
        last_step  = (cnt == CW'(WIDTH - 1));
`endif
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid) state_nxt = RUN;
            RUN:     if (last_step) state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            acc    <= '0;
            mcand  <= '0;
            mplr   <= '0;
            cnt    <= '0;
            result <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        mcand <= {{WIDTH{1'b0}}, a};
                        mplr  <= b;
                        acc   <= '0;
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    acc   <= acc_step;
                    mcand <= mcand << 1;
                    mplr  <= mplr_shift;
                    cnt   <= cnt + 1'b1;
                    if (last_step) result <= acc_step;
                end
                default: ;
            endcase
        end
    end

    // Outputs are forced quiet while reset is asserted.
    assign in_ready  = rst_n && (state == IDLE);
    assign out_valid = rst_n && (state == DONE);
    assign busy      = rst_n && (state != IDLE);
    assign p         = rst_n ? result : '0;

endmodule

// File: tb/tb_seq_multiplier.sv
// Directed self-checking bench for seq_multiplier (WIDTH=4 and WIDTH=8).
// Latency expectations follow SEQ_MULTIPLIER_EARLY_TERM_EN when defined.
module tb_seq_multiplier;

    logic        clk;
    logic        rst_n;

    logic        iv4, ir4, ov4, or4, busy4;
    logic [3:0]  a4, b4;
    logic [7:0]  p4;

    logic        iv8, ir8, ov8, or8, busy8;
    logic [7:0]  a8, b8;
    logic [15:0] p8;

    int total = 0;
    int bad   = 0;

    seq_multiplier #(.WIDTH(4)) u4 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(iv4), .in_ready(ir4),
        .a(a4), .b(b4),
        .out_valid(ov4), .out_ready(or4),
        .p(p4), .busy(busy4)
    );

    seq_multiplier #(.WIDTH(8)) u8 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(iv8), .in_ready(ir8),
        .a(a8), .b(b8),
        .out_valid(ov8), .out_ready(or8),
        .p(p8), .busy(busy8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycles from accept edge to out_valid for a given multiplier.
    function automatic int lat(input logic [31:0] bb, input int w);
`ifdef SEQ_MULTIPLIER_EARLY_TERM_EN
        int l = 1;
        for (int i = 0; i < w; i++) if (bb[i]) l = i + 1;
        return l;
`else
        return w;
`endif
    endfunction

    task automatic op8(input logic [7:0] ta, input logic [7:0] tb_,
                       input logic [15:0] ep, input int el, input string nm);
        int k;
        @(negedge clk);
        total++;
        if (ir8 !== 1'b1) begin
            bad++;
            $display("FAIL %s_ready: got %b want 1", nm, ir8);
        end
        iv8 = 1'b1; a8 = ta; b8 = tb_; or8 = 1'b1;
        @(negedge clk);
        iv8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom);
        k = 0;
        while (ov8 !== 1'b1 && k < 40) begin
            @(negedge clk);
            k++;
        end
        total++;
        if (k !== el) begin
            bad++;
            $display("FAIL %s_lat: got %0d want %0d", nm, k, el);
        end
        total++;
        if (p8 !== ep) begin
            bad++;
            $display("FAIL %s_p: got %0d want %0d", nm, p8, ep);
        end
        @(negedge clk);
        total++;
        if ({ov8, ir8} !== 2'b01 || p8 !== ep) begin
            bad++;
            $display("FAIL %s_after: ov=%b ir=%b p=%0d want ov=0 ir=1 p=%0d",
                     nm, ov8, ir8, p8, ep);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        iv4 = 1'b0; a4 = '0; b4 = '0; or4 = 1'b1;
        iv8 = 1'b0; a8 = '0; b8 = '0; or8 = 1'b1;
        repeat (2) @(negedge clk);
        total++;
        if ({ov8, busy8, ir8, p8, ov4, busy4, ir4, p4} !== '0) begin
            bad++;
            $display("FAIL reset_outs: ov8=%b busy8=%b ir8=%b p8=%0d ov4=%b busy4=%b ir4=%b p4=%0d want all 0",
                     ov8, busy8, ir8, p8, ov4, busy4, ir4, p4);
        end
        rst_n = 1'b1;
        @(negedge clk);
        total++;
        if ({ir8, ir4, busy8, busy4} !== 4'b1100) begin
            bad++;
            $display("FAIL reset_release: ir8=%b ir4=%b busy8=%b busy4=%b want 1100",
                     ir8, ir4, busy8, busy4);
        end
    endtask

    task automatic test_basic4();
        int k;
        @(negedge clk);
        total++;
        if (ir4 !== 1'b1) begin
            bad++;
            $display("FAIL b4_ready: got %b want 1", ir4);
        end
        iv4 = 1'b1; a4 = 4'd13; b4 = 4'd11; or4 = 1'b1;
        @(negedge clk);
        iv4 = 1'b0; a4 = 4'd2; b4 = 4'd3;
        k = 0;
        while (ov4 !== 1'b1 && k < 40) begin
            @(negedge clk);
            k++;
        end
        total++;
        if (k !== lat(32'd11, 4)) begin
            bad++;
            $display("FAIL b4_lat: got %0d want %0d", k, lat(32'd11, 4));
        end
        total++;
        if (p4 !== 8'd143 || busy4 !== 1'b1) begin
            bad++;
            $display("FAIL b4_p: got p=%0d busy=%b want p=143 busy=1", p4, busy4);
        end
        @(negedge clk);
        total++;
        if ({ov4, ir4} !== 2'b01 || p4 !== 8'd143) begin
            bad++;
            $display("FAIL b4_pulse: ov=%b ir=%b p=%0d want ov=0 ir=1 p=143", ov4, ir4, p4);
        end
    endtask

    task automatic test_wide();
        op8(8'd255, 8'd255, 16'd65025, lat(32'd255, 8), "w255");
        op8(8'd0, 8'd9, 16'd0, lat(32'd9, 8), "w0x9");
    endtask

    task automatic test_early_term();
        op8(8'd77, 8'd0, 16'd0, lat(32'd0, 8), "et_b0");
        op8(8'd200, 8'd1, 16'd200, lat(32'd1, 8), "et_b1");
        op8(8'd10, 8'd5, 16'd50, lat(32'd5, 8), "et_b5");
    endtask

    task automatic test_backpressure();
        int k;
        @(negedge clk);
        or8 = 1'b0;
        total++;
        if (ir8 !== 1'b1) begin
            bad++;
            $display("FAIL bp_ready: got %b want 1", ir8);
        end
        iv8 = 1'b1; a8 = 8'd15; b8 = 8'd15;
        @(negedge clk);
        a8 = 8'd1; b8 = 8'd1;
        k = 0;
        while (ov8 !== 1'b1 && k < 40) begin
            @(negedge clk);
            k++;
        end
        total++;
        if (k !== lat(32'd15, 8) || p8 !== 16'd225) begin
            bad++;
            $display("FAIL bp_first: lat=%0d p=%0d want lat=%0d p=225",
                     k, p8, lat(32'd15, 8));
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++;
            if ({ov8, ir8, busy8} !== 3'b101 || p8 !== 16'd225) begin
                bad++;
                $display("FAIL bp_hold%0d: ov=%b ir=%b busy=%b p=%0d want ov=1 ir=0 busy=1 p=225",
                         i, ov8, ir8, busy8, p8);
            end
        end
        or8 = 1'b1;
        @(negedge clk);
        total++;
        if ({ov8, ir8, busy8} !== 3'b010 || p8 !== 16'd225) begin
            bad++;
            $display("FAIL bp_release: ov=%b ir=%b busy=%b p=%0d want ov=0 ir=1 busy=0 p=225",
                     ov8, ir8, busy8, p8);
        end
        iv8 = 1'b0;
    endtask

    task automatic test_reset_mid();
        bit seen;
        @(negedge clk);
        or8 = 1'b1;
        iv8 = 1'b1; a8 = 8'd7; b8 = 8'd6;
        @(negedge clk);
        iv8 = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        total++;
        if ({ov8, busy8, ir8} !== 3'b000 || p8 !== 16'd0) begin
            bad++;
            $display("FAIL rm_low: ov=%b busy=%b ir=%b p=%0d want all 0", ov8, busy8, ir8, p8);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        total++;
        if ({ov8, busy8, ir8} !== 3'b001 || p8 !== 16'd0) begin
            bad++;
            $display("FAIL rm_after: ov=%b busy=%b ir=%b p=%0d want ov=0 busy=0 ir=1 p=0",
                     ov8, busy8, ir8, p8);
        end
        seen = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (ov8 === 1'b1) seen = 1'b1;
        end
        total++;
        if (seen !== 1'b0) begin
            bad++;
            $display("FAIL rm_no_valid: got %b want 0", seen);
        end
        op8(8'd3, 8'd5, 16'd15, lat(32'd5, 8), "rm_next");
    endtask

    task automatic test_back_to_back();
        logic [7:0]  pa [3];
        logic [7:0]  pb [3];
        int          pe [3];
        int          acc_t [3];
        logic [15:0] got [3];
        int c, nx, nr;
        pa = '{8'd2, 8'd4, 8'd9};
        pb = '{8'd3, 8'd5, 8'd9};
        pe = '{6, 20, 81};
        @(negedge clk);
        or8 = 1'b1;
        iv8 = 1'b1; a8 = pa[0]; b8 = pb[0];
        c = 0; nx = 0; nr = 0;
        while (nr < 3 && c < 200) begin
            if (ir8 && iv8) begin
                acc_t[nx] = c;
                nx++;
            end
            @(negedge clk);
            c++;
            if (ov8) begin
                got[nr] = p8;
                nr++;
            end
            if (ir8) begin
                if (nx < 3) begin
                    a8 = pa[nx]; b8 = pb[nx];
                end else begin
                    iv8 = 1'b0;
                end
            end
        end
        iv8 = 1'b0;
        total++;
        if (nr !== 3 || nx !== 3) begin
            bad++;
            $display("FAIL b2b_count: results=%0d accepts=%0d want 3 3", nr, nx);
        end else begin
            for (int i = 0; i < 3; i++) begin
                total++;
                if (got[i] !== 16'(pe[i])) begin
                    bad++;
                    $display("FAIL b2b_p%0d: got %0d want %0d", i, got[i], pe[i]);
                end
            end
            for (int i = 0; i < 2; i++) begin
                total++;
                if (acc_t[i+1] - acc_t[i] !== lat(32'(pb[i]), 8) + 2) begin
                    bad++;
                    $display("FAIL b2b_gap%0d: got %0d want %0d",
                             i, acc_t[i+1] - acc_t[i], lat(32'(pb[i]), 8) + 2);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic4();
        test_wide();
        test_early_term();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
